// File: rtl/rpsc_card7_fault_sequencer.sv
// rtl/rpsc_card7_fault_sequencer.sv - card-7 fault latch reset/lamp-test sequencer with first-out capture
// Conditions the RESET and LAMP TEST buttons and sequences the shared latch-reset line.
module rpsc_card7_fault_sequencer #(
   parameter int N_FAULT          = 8,
   parameter int DEBOUNCE_CYCLES  = 50000,
   parameter int LT_MIN_CYCLES    = 500000,
   parameter int CLR_PULSE_CYCLES = 16,
   parameter int SETTLE_CYCLES    = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [N_FAULT-1:0]         fault_in,
   input  logic                       pb_reset,
   input  logic                       pb_lamp_test,
   output logic                       ff_reset,
   output logic                       la_test,
   output logic                       trip,
   output logic                       first_valid,
   output logic [$clog2(N_FAULT)-1:0] first_out,
   output logic                       clear_fail,
   output logic                       busy
);

   localparam int FW   = $clog2(N_FAULT);
   localparam int DW   = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam int LW   = $clog2(LT_MIN_CYCLES) + 1;
   localparam int PMAX = (CLR_PULSE_CYCLES > SETTLE_CYCLES) ? CLR_PULSE_CYCLES : SETTLE_CYCLES;
   localparam int PW   = $clog2(PMAX) + 1;

   typedef enum logic [1:0] {S_CLEAR, S_SETTLE, S_ARMED, S_TRIPPED} state_t;

   // Index 0 = RESET button, index 1 = LAMP TEST button
   logic [1:0]    raw;
   logic [1:0]    sync1;
   logic [1:0]    sync2;
   logic [1:0]    deb;
   logic [1:0]    deb_d;
   logic [1:0]    press;
   logic [DW-1:0] dcnt [2];

   assign raw   = {pb_lamp_test, pb_reset};
   assign press = deb & ~deb_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1   <= '0;
         sync2   <= '0;
         deb     <= '0;
         deb_d   <= '0;
         dcnt[0] <= '0;
         dcnt[1] <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         deb_d <= deb;
         for (int b = 0; b < 2; b++) begin
            if (sync2[b] == deb[b]) begin
               dcnt[b] <= '0;
            end else if (dcnt[b] == DW'(DEBOUNCE_CYCLES - 1)) begin
               deb[b]  <= sync2[b];
               dcnt[b] <= '0;
            end else begin
               dcnt[b] <= dcnt[b] + 1'b1;
            end
         end
      end
   end

   logic [LW-1:0] lt_cnt;
   logic [LW-1:0] lt_cnt_next;

   always_comb begin
      lt_cnt_next = lt_cnt;
      if (press[1]) begin
         lt_cnt_next = LW'(LT_MIN_CYCLES);
      end else if (lt_cnt != '0) begin
         lt_cnt_next = lt_cnt - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lt_cnt  <= '0;
         la_test <= 1'b0;
      end else begin
         lt_cnt  <= lt_cnt_next;
         la_test <= deb[1] | (lt_cnt_next != '0);
      end
   end

   function automatic logic [FW-1:0] lowest_set(input logic [N_FAULT-1:0] v);
      lowest_set = '0;
      for (int i = N_FAULT - 1; i >= 0; i--) begin
         if (v[i]) lowest_set = FW'(i);
      end
   endfunction

   state_t        state;
   state_t        state_next;
   logic [PW-1:0] cnt;
   logic [PW-1:0] cnt_next;
   logic          trip_next;
   logic          fv_next;
   logic [FW-1:0] fo_next;
   logic          cf_next;

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      trip_next  = trip;
      fv_next    = first_valid;
      fo_next    = first_out;
      cf_next    = clear_fail;
      case (state)
         S_CLEAR: begin
            if (cnt == PW'(CLR_PULSE_CYCLES - 1)) begin
               state_next = S_SETTLE;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt + 1'b1;
            end
         end
         S_SETTLE: begin
            if (cnt == PW'(SETTLE_CYCLES - 1)) begin
               cnt_next = '0;
               if (fault_in == '0) begin
                  state_next = S_ARMED;
                  fv_next    = 1'b0;
                  cf_next    = 1'b0;
                  trip_next  = 1'b0;
               end else begin
                  state_next = S_TRIPPED;
                  cf_next    = 1'b1;
                  trip_next  = 1'b1;
                  fv_next    = 1'b1;
                  fo_next    = lowest_set(fault_in);
               end
            end else begin
               cnt_next = cnt + 1'b1;
            end
         end
         S_ARMED: begin
            // A fault arriving with a reset press wins: the trip must not be lost
            if (fault_in != '0) begin
               state_next = S_TRIPPED;
               trip_next  = 1'b1;
               fv_next    = 1'b1;
               fo_next    = lowest_set(fault_in);
            end else if (press[0]) begin
               state_next = S_CLEAR;
               cnt_next   = '0;
            end
         end
         S_TRIPPED: begin
            if (press[0]) begin
               state_next = S_CLEAR;
               cnt_next   = '0;
            end
         end
         default: begin
            state_next = S_CLEAR;
            cnt_next   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= S_CLEAR;
         cnt         <= '0;
         ff_reset    <= 1'b1;
         trip        <= 1'b1;
         first_valid <= 1'b0;
         first_out   <= '0;
         clear_fail  <= 1'b0;
      end else begin
         state       <= state_next;
         cnt         <= cnt_next;
         ff_reset    <= (state_next == S_CLEAR);
         trip        <= trip_next;
         first_valid <= fv_next;
         first_out   <= fo_next;
         clear_fail  <= cf_next;
      end
   end

   assign busy = (state == S_CLEAR) || (state == S_SETTLE);

endmodule

// File: tb/tb_rpsc_card7_fault_sequencer.sv
// tb/tb_rpsc_card7_fault_sequencer.sv - self-checking bench for rpsc_card7_fault_sequencer
// Short debounce and lamp-test parameters keep the run brief.
module tb_rpsc_card7_fault_sequencer;

   localparam int D   = 8;
   localparam int LT  = 100;
   localparam int CLR = 16;
   localparam int ST  = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] fault_in = 8'h00;
   logic       pb_reset = 1'b0;
   logic       pb_lamp_test = 1'b0;
   logic       ff_reset;
   logic       la_test;
   logic       trip;
   logic       first_valid;
   logic [2:0] first_out;
   logic       clear_fail;
   logic       busy;

   int n_cmp = 0;
   int n_err = 0;

   rpsc_card7_fault_sequencer #(
      .N_FAULT(8),
      .DEBOUNCE_CYCLES(D),
      .LT_MIN_CYCLES(LT),
      .CLR_PULSE_CYCLES(CLR),
      .SETTLE_CYCLES(ST)
   ) dut (
      .clk(clk),
      .reset(reset),
      .fault_in(fault_in),
      .pb_reset(pb_reset),
      .pb_lamp_test(pb_lamp_test),
      .ff_reset(ff_reset),
      .la_test(la_test),
      .trip(trip),
      .first_valid(first_valid),
      .first_out(first_out),
      .clear_fail(clear_fail),
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic int lowest(input logic [7:0] v);
      for (int i = 0; i < 8; i++) begin
         if (v[i]) return i;
      end
      return 0;
   endfunction

   // Follows one clear sequence from its first ff_reset cycle; latches reload to persist while ff_reset is high
   task automatic run_clear_seq(input logic [7:0] persist, output int nff, output int nbusy, output int ntrip0);
      nff = 0;
      nbusy = 0;
      ntrip0 = 0;
      for (int i = 0; i < 200; i++) begin
         if (ff_reset) begin
            nff++;
            fault_in = persist;
         end
         if (!busy) break;
         nbusy++;
         if (!trip) ntrip0++;
         tick();
      end
   endtask

   task automatic press_reset_btn(output int lat);
      pb_reset = 1'b1;
      lat = 0;
      while (!ff_reset && lat < 100) begin
         tick();
         lat++;
      end
      pb_reset = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b0;
      fault_in = 8'h00;
      tick();
      tick();
      n_cmp++;
      if ({ff_reset, busy, trip, la_test, first_valid, first_out, clear_fail} !== 9'b1_1_1_0_0_000_0) begin
         n_err++;
         $display("FAIL reset_state: got %b want 111000000",
                  {ff_reset, busy, trip, la_test, first_valid, first_out, clear_fail});
      end
   endtask

   task automatic test_powerup;
      int nff, nbusy, nt;
      reset = 1'b1;
      run_clear_seq(8'h00, nff, nbusy, nt);
      n_cmp++;
      if (nff !== CLR) begin n_err++; $display("FAIL powerup_ff_width: got %0d want %0d", nff, CLR); end
      n_cmp++;
      if (nbusy !== CLR + ST) begin n_err++; $display("FAIL powerup_busy_width: got %0d want %0d", nbusy, CLR + ST); end
      n_cmp++;
      if ({trip, first_valid, clear_fail} !== 3'b000) begin
         n_err++;
         $display("FAIL powerup_armed: got trip/fv/cf %b want 000", {trip, first_valid, clear_fail});
      end
   endtask

   task automatic test_simultaneous;
      fault_in = 8'b0010_1000;
      n_cmp++;
      if (trip !== 1'b0) begin n_err++; $display("FAIL simul_pre_edge: got trip %b want 0", trip); end
      tick();
      n_cmp++;
      if ({trip, first_valid, first_out} !== {1'b1, 1'b1, 3'd3}) begin
         n_err++;
         $display("FAIL simul_capture: got trip/fv/fo %b/%b/%0d want 1/1/3", trip, first_valid, first_out);
      end
      fault_in = 8'b0000_0001;
      tick();
      tick();
      n_cmp++;
      if ({trip, first_out} !== {1'b1, 3'd3}) begin
         n_err++;
         $display("FAIL simul_frozen: got trip/fo %b/%0d want 1/3", trip, first_out);
      end
   endtask

   task automatic test_clear_success;
      int lat, nff, nbusy, nt;
      press_reset_btn(lat);
      n_cmp++;
      if (lat !== D + 3) begin n_err++; $display("FAIL press_latency: got %0d want %0d", lat, D + 3); end
      run_clear_seq(8'h00, nff, nbusy, nt);
      n_cmp++;
      if (nff !== CLR) begin n_err++; $display("FAIL clear_ff_width: got %0d want %0d", nff, CLR); end
      n_cmp++;
      if (nt !== 0) begin n_err++; $display("FAIL clear_trip_held: got %0d trip-low cycles want 0", nt); end
      n_cmp++;
      if ({trip, clear_fail, first_valid} !== 3'b000) begin
         n_err++;
         $display("FAIL clear_armed: got trip/cf/fv %b want 000", {trip, clear_fail, first_valid});
      end
   endtask

   task automatic test_persistent;
      int lat, nff, nbusy, nt;
      fault_in = 8'h04;
      tick();
      n_cmp++;
      if (first_out !== 3'd2) begin n_err++; $display("FAIL persist_first: got %0d want 2", first_out); end
      press_reset_btn(lat);
      run_clear_seq(8'h40, nff, nbusy, nt);
      n_cmp++;
      if ({trip, clear_fail, first_valid, first_out} !== {1'b1, 1'b1, 1'b1, 3'd6}) begin
         n_err++;
         $display("FAIL persist_result: got trip/cf/fv/fo %b/%b/%b/%0d want 1/1/1/6",
                  trip, clear_fail, first_valid, first_out);
      end
      press_reset_btn(lat);
      run_clear_seq(8'h00, nff, nbusy, nt);
      n_cmp++;
      if ({trip, clear_fail} !== 2'b00) begin
         n_err++;
         $display("FAIL persist_reclear: got trip/cf %b want 00", {trip, clear_fail});
      end
   endtask

   task automatic test_random_faults;
      int lat, nff, nbusy, nt, exp_fo;
      logic [7:0] v, w, p;
      for (int it = 0; it < 8; it++) begin
         v = 8'($urandom_range(1, 255));
         w = 8'($urandom_range(1, 255));
         p = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(1, 255)) : 8'h00;
         exp_fo = lowest(v);
         fault_in = v;
         tick();
         n_cmp++;
         if ({trip, first_valid, first_out} !== {1'b1, 1'b1, 3'(exp_fo)}) begin
            n_err++;
            $display("FAIL rand_capture[%0d]: v=%b got trip/fv/fo %b/%b/%0d want 1/1/%0d",
                     it, v, trip, first_valid, first_out, exp_fo);
         end
         fault_in = v | w;
         tick();
         n_cmp++;
         if (first_out !== 3'(exp_fo)) begin
            n_err++;
            $display("FAIL rand_frozen[%0d]: got %0d want %0d", it, first_out, exp_fo);
         end
         press_reset_btn(lat);
         run_clear_seq(p, nff, nbusy, nt);
         if (p != 8'h00) exp_fo = lowest(p);
         n_cmp++;
         if ({trip, clear_fail, first_valid, first_out} !== {(p != 0), (p != 0), (p != 0), 3'(exp_fo)}) begin
            n_err++;
            $display("FAIL rand_clear[%0d]: p=%b got trip/cf/fv/fo %b/%b/%b/%0d want %b/%b/%b/%0d",
                     it, p, trip, clear_fail, first_valid, first_out, p != 0, p != 0, p != 0, exp_fo);
         end
         if (p != 8'h00) begin
            press_reset_btn(lat);
            run_clear_seq(8'h00, nff, nbusy, nt);
         end
      end
   endtask

   task automatic test_lamp_test;
      int lat, nla, disturbed;
      logic seen;
      fault_in = 8'h10;
      tick();
      seen = 1'b0;
      disturbed = 0;
      for (int i = 0; i < 30; i++) begin
         if (i % 3 == 0) pb_lamp_test = ~pb_lamp_test;
         tick();
         if (la_test) seen = 1'b1;
      end
      pb_lamp_test = 1'b0;
      for (int i = 0; i < D + 4; i++) begin
         tick();
         if (la_test) seen = 1'b1;
      end
      n_cmp++;
      if (seen !== 1'b0) begin n_err++; $display("FAIL lt_bounce: got la_test %b want 0", seen); end
      pb_lamp_test = 1'b1;
      lat = 0;
      while (!la_test && lat < 200) begin
         if (lat == 10) pb_lamp_test = 1'b0;
         tick();
         lat++;
      end
      pb_lamp_test = 1'b0;
      n_cmp++;
      if (lat !== D + 3) begin n_err++; $display("FAIL lt_latency: got %0d want %0d", lat, D + 3); end
      nla = 0;
      while (la_test && nla < 1000) begin
         nla++;
         if ({trip, first_valid, first_out, busy} !== {1'b1, 1'b1, 3'd4, 1'b0}) disturbed++;
         tick();
      end
      n_cmp++;
      if (nla < LT || nla > LT + D + 4) begin
         n_err++;
         $display("FAIL lt_duration: got %0d want %0d..%0d", nla, LT, LT + D + 4);
      end
      n_cmp++;
      if (disturbed !== 0) begin n_err++; $display("FAIL lt_isolation: got %0d disturbed cycles want 0", disturbed); end
   endtask

   task automatic test_reset_mid_clear;
      int lat, nff, nbusy, nt;
      press_reset_btn(lat);
      fault_in = 8'h00;
      for (int i = 0; i < 5; i++) tick();
      reset = 1'b0;
      #1;
      n_cmp++;
      if ({ff_reset, busy, trip, la_test, first_valid, first_out, clear_fail} !== 9'b1_1_1_0_0_000_0) begin
         n_err++;
         $display("FAIL midclear_async: got %b want 111000000",
                  {ff_reset, busy, trip, la_test, first_valid, first_out, clear_fail});
      end
      tick();
      reset = 1'b1;
      run_clear_seq(8'h00, nff, nbusy, nt);
      n_cmp++;
      if (nff !== CLR) begin n_err++; $display("FAIL midclear_ff_width: got %0d want %0d", nff, CLR); end
      n_cmp++;
      if ({trip, first_valid} !== 2'b00) begin
         n_err++;
         $display("FAIL midclear_armed: got trip/fv %b want 00", {trip, first_valid});
      end
   endtask

   initial begin
      test_reset();
      test_powerup();
      test_simultaneous();
      test_clear_success();
      test_persistent();
      test_random_faults();
      test_lamp_test();
      test_reset_mid_clear();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/rpsc_card7_fault_sequencer.md
# rpsc_card7_fault_sequencer

Controller for the card-7 bank of eight latched protection fault flip-flops (emergency, card position, air grid/anode, water heat exchanger/anode, door PAMP, GR switch). It conditions the operator RESET and LAMP TEST pushbuttons and sequences the shared latch-reset and lamp-test lines. It also records the first-out fault and drives the card trip output. It sits between the front-panel buttons and the eight fault latches, and consumes their latched OUT lines.

## Interface
- N_FAULT, 8: number of fault latches sequenced.
- DEBOUNCE_CYCLES, 50000: consecutive stable cycles required before a synchronized button level is accepted.
- LT_MIN_CYCLES, 500000: minimum lamp-test duration after a press.
- CLR_PULSE_CYCLES, 16: width of the latch-reset pulse.
- SETTLE_CYCLES, 4: wait after the reset pulse before fault lines are re-checked.

- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- fault_in  in  N_FAULT  latched fault OUT lines, 1 = fault; synchronous to clk; bit 0 = FF1 emergency … bit 7 = FF8 GR switch.
- pb_reset  in  1  raw operator RESET button, active-high, asynchronous.
- pb_lamp_test  in  1  raw LAMP TEST button, active-high, asynchronous.
- ff_reset  out  1  active-high reset to all fault latches.
- la_test  out  1  lamp-test drive to all fault latches.
- trip  out  1  card trip, 1 = tripped.
- first_valid  out  1  first_out holds a captured fault.
- first_out  out  $clog2(N_FAULT)  index of first-out fault.
- clear_fail  out  1  sticky; the last clear attempt found faults still present.
- busy  out  1  a clear sequence is in progress.

## Operation
- Buttons: each button passes through a 2-flop synchronizer and then a debounce counter. The debounced level changes only after the synchronized level has differed from it for DEBOUNCE_CYCLES consecutive cycles. The counter restarts on any bounce. A press event is a 0→1 transition of the debounced level, one cycle wide.
- Main FSM states: CLEAR, SETTLE, ARMED, TRIPPED.
  - CLEAR: ff_reset=1, busy=1. Counts CLR_PULSE_CYCLES, then goes to SETTLE.
  - SETTLE: ff_reset=0, busy=1. Counts SETTLE_CYCLES, then samples fault_in.
    - If fault_in is zero: go to ARMED, first_valid←0, clear_fail←0, trip←0.
    - If fault_in is nonzero: go to TRIPPED, clear_fail←1, trip←1, first_valid←1, first_out←lowest set index.
  - ARMED: any fault_in bit set → TRIPPED, trip←1, first_valid←1, first_out←lowest set index. Simultaneous faults resolve to the lowest index. A reset press → CLEAR.
  - TRIPPED: first_out is frozen; later faults never overwrite it. A reset press → CLEAR. trip stays 1 through CLEAR and SETTLE until SETTLE resolves to ARMED.
- Ignored events:
  - fault_in is ignored in CLEAR and SETTLE, because the latches are being reset.
  - Reset presses in CLEAR or SETTLE are ignored; they are not queued.
- Lamp test runs independently of the main FSM.
  - A press loads a down-counter with LT_MIN_CYCLES.
  - la_test = debounced lamp-test level OR (counter ≠ 0).
  - Lamp test never alters trip, first_out, first_valid or the FSM.
  - Lamp test is honoured in every state, including CLEAR.
- Counters are sized by $clog2 of their parameter plus 1 and saturate at 0. There is no wrap-around.

## Timing
- While reset=0: state=CLEAR, counters=0, ff_reset=1, busy=1, trip=1, la_test=0, first_valid=0, first_out=0, clear_fail=0, debounced levels=0.
- After reset rises: ff_reset stays 1 for exactly CLR_PULSE_CYCLES cycles, then SETTLE runs for SETTLE_CYCLES, then the FSM resolves as above. Power-up therefore always clears the latches.
- Reset asserted mid-operation: all state returns to the reset values immediately (asynchronous). The sequence restarts from CLEAR.
- Fault to trip: fault_in high at clock edge N gives trip, first_valid and first_out valid after edge N+1. All three are registered together.
- Button to action:
  - A clean press is a press event at edge 2+DEBOUNCE_CYCLES after the raw rise (synchronizer plus debounce).
  - ff_reset rises one cycle after the reset press event.
  - la_test rises one cycle after the lamp-test press event.
- ff_reset is glitch-free: it is driven from a register only.

## Test plan
- Power-up: release reset → ff_reset=1 for 16 cycles, busy=1 for 20, then ARMED with trip=0, first_valid=0 (fault_in=0).
- Simultaneous faults: fault_in=8'b0010_1000 in ARMED → next cycle trip=1, first_out=3. A later fault_in=8'b0000_0001 leaves first_out=3.
- Successful clear: TRIPPED, model the latches clearing on ff_reset, press pb_reset → ff_reset pulse of 16 cycles, then ARMED, trip=0, clear_fail=0.
- Persistent fault: hold fault_in[6]=1 through the clear → after SETTLE, TRIPPED with clear_fail=1 and first_out=6. Re-clear with faults gone → clear_fail=0.
- Debounce and lamp test: with DEBOUNCE_CYCLES=8 and LT_MIN_CYCLES=100, bounce pb_lamp_test every 3 cycles → no press. Then hold it for 10 cycles → la_test=1 for ≥100 cycles, with trip and first_out unchanged.
- Reset mid-CLEAR: drop reset at cycle 5 of CLEAR → outputs return to reset values immediately. After release, a full 16-cycle ff_reset pulse is issued.
